sd_cmd_responder: RTL

//  Card-side SD CMD-line engine, the counterpart of the host controller: decodes 48-bit host command frames and transmits R1/R3/R6/R7 (48-bit) or R2 (136-bit) responses.

---
 rtl/sd_cmd_responder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_responder.sv
// rtl/sd_cmd_responder.sv - card-side SD CMD line engine: command decode and response transmit
//
// Samples the host CMD line on sd_clk rising edges and decodes 48-bit command
// frames into cmd_index/cmd_arg with a valid/ready handshake. Responses are
// taken with a valid/ready handshake and shifted out on sd_clk falling edges
// as 48-bit (R1/R3/R6/R7) or 136-bit (R2) frames.
//
// Configuration macro: SD_CMD_CRC_CHECK_EN
//   defined   - received CRC7 field is checked; a bad CRC drops the frame
//   undefined - received CRC7 field is ignored (end bit / tx bit still checked)
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   sd_clk                host card clock, sampled (clk must be >= 4x sd_clk)
//   cmd_in                CMD pin input
//   cmd_out, cmd_oe       CMD pin drive value and output enable
//   cmd_valid/cmd_ready   decoded command handshake
//   cmd_index, cmd_arg    decoded command fields
//   cmd_overrun           1-clk pulse: unaccepted command overwritten
//   crc_err               1-clk pulse: received frame dropped
//   rsp_valid/rsp_ready   response handshake (rsp_ready is a 1-clk pulse)
//   rsp_long, rsp_nocrc   R2 frame select, send 7'h7F instead of CRC7
//   rsp_data              short: [37:0] index,arg; long: [127:1] verbatim

module sd_cmd_responder #(
  parameter int NCR_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sd_clk,
  input  logic         cmd_in,
  output logic         cmd_out,
  output logic         cmd_oe,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_arg,
  output logic         cmd_overrun,
  output logic         crc_err,
  input  logic         rsp_valid,
  output logic         rsp_ready,
  input  logic         rsp_long,
  input  logic         rsp_nocrc,
  input  logic [127:0] rsp_data
);

  typedef enum logic [1:0] {IDLE, RX, WAIT, TX} state_t;

  localparam logic [7:0] NCR_MIN = 8'(NCR_CYCLES);

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  state_t         state_q;
  logic [2:0]     sclk_q;
  logic [1:0]     cmd_sync_q;
  logic [46:0]    rx_sh_q;
  logic [6:0]     crc_q;
  logic [7:0]     bit_cnt_q;
  logic [7:0]     ncr_cnt_q;
  logic [135:0]   tx_sh_q;
  logic           cmd_out_q, cmd_oe_q, cmd_valid_q, cmd_overrun_q, crc_err_q, rsp_ready_q;
  logic [5:0]     cmd_index_q;
  logic [31:0]    cmd_arg_q;

  logic           rise, fall, cmd_s, accept, crc_ok, frame_ok, launch;
  logic [6:0]     crc_d;
  logic [39:0]    sframe;
  logic [6:0]     scrc;
  logic [135:0]   tx_load;

  // sclk_q[1:0] is the synchroniser, sclk_q[2] the previous value for edge detect
  assign rise   = sclk_q[1] & ~sclk_q[2];
  assign fall   = ~sclk_q[1] & sclk_q[2];
  assign cmd_s  = cmd_sync_q[1];
  assign accept = cmd_valid_q & cmd_ready;
  assign crc_d  = crc7_step(crc_q, cmd_s);

  // rx_sh_q holds frame bits 47..1 at the end bit, so the CRC field is rx_sh_q[6:0]
`ifdef SD_CMD_CRC_CHECK_EN
  assign crc_ok = (crc_q == rx_sh_q[6:0]);
`else
  logic unused_crc;
  assign unused_crc = ^{crc_q, rx_sh_q[6:0]};
  assign crc_ok = 1'b1;
`endif

  // End bit is the current sample; tx bit (frame bit 46) sits at rx_sh_q[45]
  assign frame_ok = cmd_s & rx_sh_q[45] & crc_ok;

  assign sframe  = {2'b00, rsp_data[37:0]};
  assign scrc    = rsp_nocrc ? 7'h7F : crc7_40(sframe);
  assign tx_load = rsp_long ? {2'b00, 6'h3F, rsp_data[127:1], 1'b1}
                            : {sframe, scrc, 1'b1, 88'd0};

  // ncr_cnt is forced to 255 on the way back to IDLE, so IDLE and WAIT share one rule
  assign launch = fall & rsp_valid & (ncr_cnt_q >= NCR_MIN) &
                  ((state_q == IDLE) | (state_q == WAIT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q     <= 3'b000;
      cmd_sync_q <= 2'b11;   // idle line level, so no false start bit after reset
    end else begin
      sclk_q     <= {sclk_q[1:0], sd_clk};
      cmd_sync_q <= {cmd_sync_q[0], cmd_in};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rx_sh_q       <= '0;
      crc_q         <= '0;
      bit_cnt_q     <= '0;
      ncr_cnt_q     <= '0;
      tx_sh_q       <= '0;
      cmd_out_q     <= 1'b1;
      cmd_oe_q      <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_overrun_q <= 1'b0;
      crc_err_q     <= 1'b0;
      rsp_ready_q   <= 1'b0;
      cmd_index_q   <= '0;
      cmd_arg_q     <= '0;
    end else begin
      cmd_overrun_q <= 1'b0;
      crc_err_q     <= 1'b0;
      rsp_ready_q   <= 1'b0;
      if (accept) cmd_valid_q <= 1'b0;

      case (state_q)
        IDLE, WAIT: begin
          if (rise && ncr_cnt_q != 8'hFF) ncr_cnt_q <= ncr_cnt_q + 8'd1;
          if (rise && !cmd_s) begin
            // start bit (bit 47) taken; a pending response is abandoned
            state_q   <= RX;
            rx_sh_q   <= '0;
            crc_q     <= crc7_step(7'd0, 1'b0);
            bit_cnt_q <= 8'd46;
          end else if (launch) begin
            rsp_ready_q <= 1'b1;
            cmd_out_q   <= 1'b0;
            cmd_oe_q    <= 1'b1;
            tx_sh_q     <= {tx_load[134:0], 1'b0};
            bit_cnt_q   <= rsp_long ? 8'd135 : 8'd47;
            state_q     <= TX;
          end
        end
        RX: begin
          if (rise) begin
            if (bit_cnt_q == 8'd0) begin
              if (frame_ok) begin
                cmd_index_q   <= rx_sh_q[44:39];
                cmd_arg_q     <= rx_sh_q[38:7];
                cmd_valid_q   <= 1'b1;          // overrides a same-clk accept
                cmd_overrun_q <= cmd_valid_q & ~accept;
              end else begin
                crc_err_q <= 1'b1;
              end
              ncr_cnt_q <= 8'd0;
              state_q   <= WAIT;
            end else begin
              rx_sh_q   <= {rx_sh_q[45:0], cmd_s};
              if (bit_cnt_q >= 8'd8) crc_q <= crc_d;
              bit_cnt_q <= bit_cnt_q - 8'd1;
            end
          end
        end
        TX: begin
          if (fall) begin
            if (bit_cnt_q != 8'd0) begin
              cmd_out_q <= tx_sh_q[135];
              tx_sh_q   <= {tx_sh_q[134:0], 1'b0};
              bit_cnt_q <= bit_cnt_q - 8'd1;
            end else begin
              cmd_oe_q  <= 1'b0;
              cmd_out_q <= 1'b1;
              ncr_cnt_q <= 8'hFF;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_out     = cmd_out_q;
  assign cmd_oe      = cmd_oe_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_index   = cmd_index_q;
  assign cmd_arg     = cmd_arg_q;
  assign cmd_overrun = cmd_overrun_q;
  assign crc_err     = crc_err_q;
  assign rsp_ready   = rsp_ready_q;

endmodule
